// File: rtl/skylark_pkg.sv
// Shared types and constants for the skylark instruction-fetch front end.
package skylark_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef enum logic [0:0] {FETCH, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            branched;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer of fetch entries; flush empties it in one cycle.
module fetch_fifo
  import skylark_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth) + 1,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  fetch_entry_t    wdata_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fetch_entry_t    rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A write at full is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, prefetch FIFO, redirect flush
// with discard of stale responses, and first-after-redirect tagging.
module fetch_unit #(
  parameter int unsigned            XLEN       = skylark_pkg::XLEN,
  parameter logic [XLEN-1:0]        RESET_PC   = skylark_pkg::RESET_PC,
  parameter int unsigned            FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_E,
  input  logic [XLEN-1:0] redirect_pc_E,
  input  logic            stall_D,
  output logic [XLEN-1:0] instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic            valid_D,
  output logic            branched_flag_F
);

  import skylark_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   in_flight_q, in_flight_d, discard_q, discard_d;
  logic            pending_branch_q, pending_branch_d;
  fetch_state_t    state_q, state_d;

  fetch_entry_t    fifo_wdata, fifo_head;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  logic [CW:0]     outstanding, old_stream;
  logic            accept;
  logic [1:0]      unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc_E[1:0];

  // Every word that will eventually land (or be dropped) holds a credit.
  assign outstanding = {1'b0, in_flight_q} + {1'b0, fifo_count}
                     + ((state_q == DRAIN) ? {1'b0, discard_q} : '0);

  assign imem_req  = reset_n && !redirect_E && (outstanding < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_gnt;

  assign valid_D         = !fifo_empty;
  assign instr_D         = fifo_empty ? '0 : fifo_head.instr;
  assign pc_D            = fifo_empty ? '0 : fifo_head.pc;
  assign branched_flag_F = !fifo_empty && fifo_head.branched;

  assign fifo_pop   = valid_D && !stall_D;
  assign fifo_wdata = '{instr: imem_rdata, pc: resp_pc_q, branched: pending_branch_q};

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    resp_pc_d        = resp_pc_q;
    in_flight_d      = in_flight_q;
    discard_d        = discard_q;
    pending_branch_d = pending_branch_q;
    fifo_push        = 1'b0;
    old_stream       = {1'b0, discard_q} + {1'b0, in_flight_q} + (CW + 1)'(accept);

    if (redirect_E) begin
      // A response arriving now belongs to the old stream and is dropped here.
      if (imem_rvalid && (old_stream != '0)) old_stream = old_stream - (CW + 1)'(1);
      discard_d        = old_stream[CW-1:0];
      in_flight_d      = '0;
      fetch_pc_d       = {redirect_pc_E[XLEN-1:2], 2'b00};
      resp_pc_d        = {redirect_pc_E[XLEN-1:2], 2'b00};
      pending_branch_d = 1'b1;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else if (in_flight_q != '0 && (!fifo_full || fifo_pop)) begin
          fifo_push        = 1'b1;
          resp_pc_d        = resp_pc_q + XLEN'(4);
          pending_branch_d = 1'b0;
        end
      end
      in_flight_d = in_flight_q + CW'(accept) - CW'(fifo_push);
    end

    state_d = (discard_d != '0) ? DRAIN : FETCH;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q       <= RESET_PC;
      resp_pc_q        <= RESET_PC;
      in_flight_q      <= '0;
      discard_q        <= '0;
      pending_branch_q <= 1'b0;
      state_q          <= FETCH;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      resp_pc_q        <= resp_pc_d;
      in_flight_q      <= in_flight_d;
      discard_q        <= discard_d;
      pending_branch_q <= pending_branch_d;
      state_q          <= state_d;
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect_E),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the memory model returns addr + 0x1000_0000 as the word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_E;
  logic [31:0] redirect_pc_E;
  logic        stall_D;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic        valid_D;
  logic        branched_flag_F;

  int          checks = 0;
  int          errors = 0;
  logic        rsp_en = 1'b1;
  logic [31:0] mem_q[$];

  fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_E      (redirect_E),
    .redirect_pc_E   (redirect_pc_E),
    .stall_D         (stall_D),
    .instr_D         (instr_D),
    .pc_D            (pc_D),
    .valid_D         (valid_D),
    .branched_flag_F (branched_flag_F)
  );

  always #5 clk = ~clk;

  // In-order memory: a word granted at one edge is returned in the next cycle.
  always @(posedge clk) begin
    if (imem_rvalid) void'(mem_q.pop_front());
    if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
    if (rsp_en && mem_q.size() != 0) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= mem_q[0] + 32'h1000_0000;
    end else begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'b0, imem_req}, 32'd0);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_valid"}, {31'b0, valid_D}, 32'd0);
    check({tag, "_instr"}, instr_D, 32'h0);
    check({tag, "_pc"},    pc_D, 32'h0);
    check({tag, "_flag"},  {31'b0, branched_flag_F}, 32'd0);
  endtask

  // Waits (bounded) for the next delivered instruction and consumes it.
  task automatic expect_instr(input string tag, input logic [31:0] pc, input logic flag);
    int n = 0;
    while (valid_D !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, {31'b0, valid_D}, 32'd1);
    if (valid_D === 1'b1) begin
      check({tag, "_pc"},    pc_D, pc);
      check({tag, "_instr"}, instr_D, pc + 32'h1000_0000);
      check({tag, "_flag"},  {31'b0, branched_flag_F}, {31'b0, flag});
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n       = 1'b0;
    imem_gnt      = 1'b0;
    redirect_E    = 1'b0;
    redirect_pc_E = '0;
    stall_D       = 1'b0;
    tick(2);
    check_reset_outputs("rst");

    // Streaming with an always-granting memory.
    reset_n  = 1'b1;
    imem_gnt = 1'b1;
    #1;
    check("first_req",  {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    tick(1);
    check("lat_valid0", {31'b0, valid_D}, 32'd0);
    check("second_addr", imem_addr, 32'h4);
    tick(1);
    check("lat_valid1", {31'b0, valid_D}, 32'd1);
    check("s0_pc",    pc_D, 32'h0);
    check("s0_instr", instr_D, 32'h1000_0000);
    check("s0_flag",  {31'b0, branched_flag_F}, 32'd0);
    tick(1);
    check("s4_pc", pc_D, 32'h4);
    tick(1);
    expect_instr("s8", 32'h8, 1'b0);
    expect_instr("s12", 32'hC, 1'b0);

    // Decode stall: buffer fills, requests stop, head holds.
    stall_D = 1'b1;
    tick(5);
    check("stall_req",   {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, valid_D}, 32'd1);
    check("stall_pc",    pc_D, 32'h10);
    check("stall_instr", instr_D, 32'h1000_0010);
    check("stall_addr",  imem_addr, 32'h18);
    stall_D = 1'b0;
    expect_instr("rel16", 32'h10, 1'b0);
    expect_instr("rel20", 32'h14, 1'b0);
    expect_instr("rel24", 32'h18, 1'b0);
    expect_instr("rel28", 32'h1C, 1'b0);

    // Redirect with two requests in flight.
    rsp_en = 1'b0;
    tick(8);
    check("inflight_block", {31'b0, imem_req}, 32'd0);
    redirect_E    = 1'b1;
    redirect_pc_E = 32'h103;
    #1;
    check("redir_req", {31'b0, imem_req}, 32'd0);
    tick(1);
    redirect_E = 1'b0;
    rsp_en     = 1'b1;
    check("redir_addr",  imem_addr, 32'h100);
    check("redir_valid", {31'b0, valid_D}, 32'd0);
    check("drain_req",   {31'b0, imem_req}, 32'd0);
    expect_instr("r100", 32'h100, 1'b1);
    expect_instr("r104", 32'h104, 1'b0);

    // Redirect coinciding with an old-stream response.
    rsp_en = 1'b0;
    tick(8);
    rsp_en = 1'b1;
    tick(1);
    redirect_E    = 1'b1;
    redirect_pc_E = 32'h200;
    tick(1);
    redirect_E = 1'b0;
    expect_instr("r200", 32'h200, 1'b1);
    expect_instr("r204", 32'h204, 1'b0);

    // Address wrap at the top of the space.
    redirect_E    = 1'b1;
    redirect_pc_E = 32'hFFFF_FFF8;
    tick(1);
    redirect_E = 1'b0;
    expect_instr("wrapF8", 32'hFFFF_FFF8, 1'b1);
    expect_instr("wrapFC", 32'hFFFF_FFFC, 1'b0);
    expect_instr("wrap0",  32'h0, 1'b0);

    // Reset while draining, with stale responses still to come back.
    rsp_en = 1'b0;
    tick(8);
    redirect_E    = 1'b1;
    redirect_pc_E = 32'h300;
    tick(1);
    redirect_E = 1'b0;
    reset_n    = 1'b0;
    imem_gnt   = 1'b0;
    rsp_en     = 1'b1;
    tick(1);
    check_reset_outputs("drain_rst");
    reset_n = 1'b1;
    tick(4);
    check("stale_valid", {31'b0, valid_D}, 32'd0);
    check("post_rst_req",  {31'b0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    expect_instr("pr0", 32'h0, 1'b0);
    expect_instr("pr4", 32'h4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
